sm_para_3: RTL and testbench
============================

# sm_para_3

Four-state Moore controller built in the three-block FSM style: a state register, a combinational next-state decoder and a registered output decoder. It watches two level inputs `i1`/`i2` and walks IDLE → S1 → S2 → IDLE on a legal handshake. Any illegal input combination diverts it to ERROR. It sits between a simple two-signal requester and downstream logic that consumes `o1`/`o2`/`err` as clean, glitch-free registered flags.

## Interface
- Parameters: none.
- `clk`  in  1  system clock; all state and outputs update on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i1`  in  1  request/qualifier input 1, sampled on rising `clk`.
- `i2`  in  1  request/qualifier input 2, sampled on rising `clk`.
- `o1`  out  1  registered flag, high in S1 and ERROR.
- `o2`  out  1  registered flag, high in S2 and ERROR.
- `err`  out  1  registered error flag, high only in ERROR.

## Operation
- States: IDLE, S1, S2, ERROR.
- Block 1, state register: `state <= rst ? IDLE : next_state`.
- Block 2, combinational next-state decode:
  - IDLE:
    - `i1=0` → IDLE.
    - `i1=1, i2=1` → S1.
    - `i1=1, i2=0` → ERROR.
  - S1:
    - `i2=0` → S1.
    - `i2=1, i1=1` → S2.
    - `i2=1, i1=0` → ERROR.
  - S2:
    - `i2=1` → S2.
    - `i2=0, i1=1` → IDLE.
    - `i2=0, i1=0` → ERROR.
  - ERROR:
    - `i1=1` → ERROR.
    - `i1=0` → IDLE.
  - Any unreachable/illegal encoding → IDLE.
- Block 3, registered output decode. Outputs are registered from `next_state`, so they always match the value `state` takes on the same edge:
  - IDLE: `o1=0 o2=0 err=0`.
  - S1: `o1=1 o2=0 err=0`.
  - S2: `o1=0 o2=1 err=0`.
  - ERROR: `o1=1 o2=1 err=1`.
- No latches. The combinational block carries default assignments and a default arm.

## Timing
- Reset:
  - On a rising `clk` with `rst=1`: `state=IDLE`, `o1=0`, `o2=0`, `err=0`.
  - `rst` has priority over all inputs.
- Reset mid-operation, from any state: IDLE and all-zero outputs on that same edge.
- On the first edge after `rst` falls, the transition is evaluated from IDLE using the `i1`/`i2` values sampled at that edge.
- Latency: an input change sampled at edge N moves `state` and the outputs together at edge N; the result is visible after that edge.
- No combinational path from inputs to outputs.
- Inputs must meet setup/hold to `clk`. No internal synchronizers.
- Self-loops hold the outputs stable. No output pulses on a self-loop.

## Configuration
- `SM_PARA_3_ONEHOT_EN`:
  - Defined: four-bit one-hot state encoding (IDLE=0001, S1=0010, S2=0100, ERROR=1000). Any non-one-hot value recovers to IDLE on the next edge.
  - Undefined: two-bit binary encoding (IDLE=00, S1=01, S2=10, ERROR=11).
- Port behaviour is cycle-identical in both builds.

## Test plan
- Reset: `rst=1` for 2 edges with `i1=1, i2=0` → `o1=0, o2=0, err=0` after each reset edge.
- Legal cycle from IDLE:
  - `i1=1, i2=1` → S1 (`o1=1`).
  - `i1=1, i2=1` → S2 (`o2=1`).
  - `i1=1, i2=0` → IDLE (all 0).
- IDLE error and recovery:
  - `i1=1, i2=0` → ERROR (`o1=o2=err=1`).
  - Hold `i1=1` for 3 edges → outputs stay 1.
  - `i1=0` → IDLE.
- S1 and S2 error paths:
  - From S1, `i1=0, i2=1` → ERROR.
  - From S2, `i1=0, i2=0` → ERROR.
- Self-loops:
  - In S1, `i2=0` with `i1` toggling for 4 edges → `o1` stays 1, no glitch.
  - In S2, `i2=1` for 4 edges → `o2` stays 1.
- Mid-operation reset and encoding check:
  - Assert `rst` while in S2 or ERROR → IDLE, outputs 0 on that edge.
  - Rerun the whole plan with `SM_PARA_3_ONEHOT_EN` defined → identical output trace.

Source files
------------

// File: rtl/sm_para_3.sv
// sm_para_3 - four-state Moore handshake controller (three-block FSM).
//
// Watches the level inputs i1/i2 and walks IDLE -> S1 -> S2 -> IDLE on a
// legal handshake; any illegal combination diverts to ERROR, which is left
// only once i1 drops. Outputs are registered from next_state, so they
// change on the same edge as state and are glitch-free.
//
// Ports:
//   clk  in   system clock, rising-edge
//   rst  in   synchronous active-high reset (priority over all inputs)
//   i1   in   request/qualifier input 1
//   i2   in   request/qualifier input 2
//   o1   out  registered flag, high in S1 and ERROR
//   o2   out  registered flag, high in S2 and ERROR
//   err  out  registered flag, high only in ERROR
//
// Build option:
//   SM_PARA_3_ONEHOT_EN  defined -> 4-bit one-hot state encoding, any
//                        non-one-hot value recovers to IDLE;
//                        undefined -> 2-bit binary encoding.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for a request (i1=1, i2=1)
// S1    | request accepted, waiting for i2 qualifier
// S2    | qualified, waiting for i2 to drop with i1 high
// ERROR | illegal input seen, held until i1 drops

module sm_para_3 (
    input  logic clk,
    input  logic rst,
    input  logic i1,
    input  logic i2,
    output logic o1,
    output logic o2,
    output logic err
);

`ifdef SM_PARA_3_ONEHOT_EN
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        S1    = 4'b0010,
        S2    = 4'b0100,
        ERROR = 4'b1000
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        S1    = 2'b01,
        S2    = 2'b10,
        ERROR = 2'b11
    } state_t;
`endif

    state_t state;
    state_t next_state;

    // Block 1: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Block 2: next-state decode
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: begin
                if (!i1)     next_state = IDLE;
                else if (i2) next_state = S1;
                else         next_state = ERROR;
            end
            S1: begin
                if (!i2)     next_state = S1;
                else if (i1) next_state = S2;
                else         next_state = ERROR;
            end
            S2: begin
                if (i2)      next_state = S2;
                else if (i1) next_state = IDLE;
                else         next_state = ERROR;
            end
            ERROR: begin
                if (i1)      next_state = ERROR;
                else         next_state = IDLE;
            end
            // Unreachable encodings (non-one-hot values in the one-hot build)
            default: next_state = IDLE;
        endcase
    end

    // Block 3: registered output decode from next_state so the flags
    // line up with the state taken on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            o1  <= 1'b0;
            o2  <= 1'b0;
            err <= 1'b0;
        end else begin
            case (next_state)
                S1: begin
                    o1  <= 1'b1;
                    o2  <= 1'b0;
                    err <= 1'b0;
                end
                S2: begin
                    o1  <= 1'b0;
                    o2  <= 1'b1;
                    err <= 1'b0;
                end
                ERROR: begin
                    o1  <= 1'b1;
                    o2  <= 1'b1;
                    err <= 1'b1;
                end
                default: begin
                    o1  <= 1'b0;
                    o2  <= 1'b0;
                    err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_para_3.sv
// Testbench for sm_para_3: directed vectors with literal expectations plus
// a table-driven reference model compared on every falling clock edge.

module tb_sm_para_3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i1  = 1'b0;
    logic i2  = 1'b0;
    logic o1, o2, err;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit chk_en   = 1'b0;

    sm_para_3 dut (
        .clk (clk),
        .rst (rst),
        .i1  (i1),
        .i2  (i2),
        .o1  (o1),
        .o2  (o2),
        .err (err)
    );

    always #5 clk = ~clk;

    // Reference model: states 0=IDLE 1=S1 2=S2 3=ERROR.
    // nxt_tbl index = state*4 + {i1,i2}.
    int nxt_tbl [16] = '{0, 0, 3, 1,     // IDLE : 00 01 10 11
                         1, 3, 1, 2,     // S1
                         3, 2, 0, 2,     // S2
                         0, 0, 3, 3};    // ERROR
    // Expected {o1,o2,err} per state.
    logic [2:0] out_tbl [4] = '{3'b000, 3'b100, 3'b010, 3'b111};
    int m_state = 0;

    always @(posedge clk) begin
        if (rst) m_state = 0;
        else     m_state = nxt_tbl[m_state*4 + int'({i1, i2})];
    end

    // Compare process: every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            chk_cnt++;
            if ({o1, o2, err} === out_tbl[m_state]) pass_cnt++;
            else $display("FAIL model_cmp t=%0t got o1o2err=%b expected=%b (model state %0d)",
                          $time, {o1, o2, err}, out_tbl[m_state], m_state);
        end
    end

    // Drive one cycle: inputs applied just after a rising edge, then wait
    // for the next rising edge and settle.
    task automatic step(input logic r, input logic a, input logic b);
        rst = r;
        i1  = a;
        i2  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [2:0] exp);
        chk_cnt++;
        if ({o1, o2, err} === exp) pass_cnt++;
        else $display("FAIL %s got o1o2err=%b expected=%b", name, {o1, o2, err}, exp);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset with i1=1, i2=0 (would be ERROR without reset)
        step(1, 1, 0); check_lit("reset_edge1", 3'b000);
        chk_en = 1'b1;
        step(1, 1, 0); check_lit("reset_edge2", 3'b000);

        // Legal cycle
        step(0, 1, 1); check_lit("idle_to_s1", 3'b100);
        step(0, 1, 1); check_lit("s1_to_s2", 3'b010);
        step(0, 1, 0); check_lit("s2_to_idle", 3'b000);

        // IDLE error and recovery
        step(0, 1, 0); check_lit("idle_to_err", 3'b111);
        step(0, 1, 0); check_lit("err_hold1", 3'b111);
        step(0, 1, 1); check_lit("err_hold2", 3'b111);
        step(0, 1, 0); check_lit("err_hold3", 3'b111);
        step(0, 0, 1); check_lit("err_to_idle", 3'b000);

        // S1 error path
        step(0, 1, 1); check_lit("s1_entry", 3'b100);
        step(0, 0, 1); check_lit("s1_to_err", 3'b111);
        step(0, 0, 0); check_lit("err_exit_a", 3'b000);

        // S2 error path
        step(0, 1, 1);
        step(0, 1, 1); check_lit("s2_entry", 3'b010);
        step(0, 0, 0); check_lit("s2_to_err", 3'b111);
        step(0, 0, 0); check_lit("err_exit_b", 3'b000);

        // S1 self-loop with i1 toggling
        step(0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            step(0, (k % 2 == 0), 0);
            check_lit("s1_selfloop", 3'b100);
        end
        // S2 self-loop
        step(0, 1, 1); check_lit("s1_to_s2_b", 3'b010);
        for (int k = 0; k < 4; k++) begin
            step(0, (k % 2 == 1), 1);
            check_lit("s2_selfloop", 3'b010);
        end

        // Mid-operation reset from S2, then from ERROR
        step(1, 1, 1); check_lit("rst_from_s2", 3'b000);
        step(0, 1, 0); check_lit("err_before_rst", 3'b111);
        step(1, 1, 0); check_lit("rst_from_err", 3'b000);
        // First edge after reset evaluates from IDLE
        step(0, 1, 1); check_lit("first_after_rst", 3'b100);

        // Pseudo-random sweep, checked by the model only
        for (int k = 0; k < 60; k++) begin
            step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
